clkdiv_gen: RTL and testbench

Parametrised multi-channel clock-enable/divided-clock generator, successor to the fixed four-output PLL wrapper. Runs on one input clock and produces NUM_CH divided outputs. Each channel has a runtime-programmable divider, phase and enable, loaded into shadow registers and applied atomically. A lock sequencer gates all outputs and reports `locked`, so downstream logic sees a PLL-like lock handshake.

---
 rtl/clkdiv_gen_pkg.sv | 36 +++
 rtl/clkdiv_chan.sv | 72 +++++++
 rtl/clkdiv_gen.sv | 101 ++++++++++
 tb/tb_clkdiv_gen.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_gen_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_gen_pkg : shared types and helpers for the clkdiv_gen block
// Revision 1.0
// ----------------------------------------------------------------------------
package clkdiv_gen_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_LOAD = 2'd1,
    ST_LOCK = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  typedef logic [31:0] word_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // LOCK counter runs 0..n-1
  function automatic int lock_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic word_t sanitise_div(input word_t d);
    return (d == '0) ? word_t'(1) : d;
  endfunction

  // d must already be sanitised
  function automatic word_t sanitise_phase(input word_t p, input word_t d);
    return (p >= d) ? (d - word_t'(1)) : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_chan : one divider channel - shadow/active config, counter, decode
// Revision 1.0
// ----------------------------------------------------------------------------
module clkdiv_chan
  import clkdiv_gen_pkg::*;
#(
  parameter int unsigned      DIV_W     = 8,
  parameter logic [DIV_W-1:0] DIV_RST   = DIV_W'(1),
  parameter logic [DIV_W-1:0] PHASE_RST = '0,
  parameter logic             EN_RST    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             cnt_en_i,
  input  logic             run_i,
  output logic             clk_en_o,
  output logic             clk_out_o,
  output logic             active_o
);

  localparam word_t       RST_DIV = sanitise_div(word_t'(DIV_RST));
  localparam word_t       RST_PH  = sanitise_phase(word_t'(PHASE_RST), RST_DIV);
  localparam int unsigned HW      = DIV_W + 1;

  logic [DIV_W-1:0] sh_div_q, sh_ph_q, act_div_q, cnt_q, cnt_d, term_w;
  logic             sh_en_q, act_en_q;
  logic [HW-1:0]    half_w;

  assign term_w = act_div_q - DIV_W'(1);
  assign half_w = ({1'b0, act_div_q} + HW'(1)) >> 1;

  always_comb begin
    cnt_d = (cnt_q == term_w) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_div_q  <= DIV_W'(RST_DIV);
      sh_ph_q   <= DIV_W'(RST_PH);
      sh_en_q   <= EN_RST;
      act_div_q <= DIV_W'(RST_DIV);
      act_en_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (wr_i) begin
        sh_div_q <= DIV_W'(sanitise_div(word_t'(div_i)));
        sh_ph_q  <= DIV_W'(sanitise_phase(word_t'(phase_i), sanitise_div(word_t'(div_i))));
        sh_en_q  <= en_i;
      end
      if (load_i) begin
        act_div_q <= sh_div_q;
        act_en_q  <= sh_en_q;
        cnt_q     <= sh_ph_q;
      end else if (cnt_en_i) begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign clk_en_o  = run_i & act_en_q & (cnt_q == term_w);
  assign clk_out_o = run_i & act_en_q & ({1'b0, cnt_q} < half_w);
  assign active_o  = act_en_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clkdiv_gen : multi-channel divided-clock generator with lock sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module clkdiv_gen
  import clkdiv_gen_pkg::*;
#(
  parameter int unsigned              NUM_CH      = 4,
  parameter int unsigned              DIV_W       = 8,
  parameter int unsigned              LOCK_CYCLES = 16,
  parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT    = {8'd12, 8'd24, 8'd23, 8'd48},
  parameter logic [NUM_CH*DIV_W-1:0]  PHASE_INIT  = '0,
  parameter logic [NUM_CH-1:0]        EN_INIT     = '1,
  localparam int                      CH_W        = ch_width(NUM_CH)
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  input  logic              commit,
  output logic              busy,
  output logic              locked,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int              LK_W    = lock_width(LOCK_CYCLES);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

  state_e          state_q, state_d;
  logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
  logic            run_w, load_w, cnt_en_w, wr_fire_w;

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      lk_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lk_cnt_q <= lk_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    case (state_q)
      ST_RUN:  if (commit) state_d = ST_STOP;
      ST_STOP: state_d = ST_LOAD;
      ST_LOAD: begin
        state_d  = ST_LOCK;
        lk_cnt_d = '0;
      end
      ST_LOCK: begin
        if (lk_cnt_q == LK_LAST) state_d = ST_RUN;
        else                     lk_cnt_d = lk_cnt_q + 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Counters keep running through LOCK so channel alignment is settled before ungating
  assign run_w     = (state_q == ST_RUN);
  assign load_w    = (state_q == ST_LOAD);
  assign cnt_en_w  = (state_q == ST_LOCK) | run_w;
  assign wr_fire_w = cfg_valid & run_w;

  assign cfg_ready = run_w;
  assign locked    = run_w;
  assign busy      = ~run_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clkdiv_chan #(
      .DIV_W     (DIV_W),
      .DIV_RST   (DIV_INIT[i*DIV_W +: DIV_W]),
      .PHASE_RST (PHASE_INIT[i*DIV_W +: DIV_W]),
      .EN_RST    (EN_INIT[i])
    ) u_chan (
      .clk_i     (refclk),
      .rst_i     (reset),
      .wr_i      (wr_fire_w && (cfg_ch == CH_W'(i))),
      .div_i     (cfg_div),
      .phase_i   (cfg_phase),
      .en_i      (cfg_en),
      .load_i    (load_w),
      .cnt_en_i  (cnt_en_w),
      .run_i     (run_w),
      .clk_en_o  (clk_en[i]),
      .clk_out_o (clk_out[i]),
      .active_o  (ch_active[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_clkdiv_gen : self-checking bench for clkdiv_gen (default parameters)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_clkdiv_gen;

  localparam int NCH = 4;
  localparam int LC  = 16;
  localparam int INIT_DIV [NCH] = '{48, 23, 24, 12};

  logic       refclk = 1'b0, reset = 1'b1, cfg_valid = 1'b0, cfg_en = 1'b0, commit = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0, cfg_phase = '0;
  logic       cfg_ready, busy, locked;
  logic [3:0] clk_en, clk_out, ch_active;

  clkdiv_gen dut (
    .refclk    (refclk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_en    (cfg_en),
    .commit    (commit),
    .busy      (busy),
    .locked    (locked),
    .clk_en    (clk_en),
    .clk_out   (clk_out),
    .ch_active (ch_active)
  );

  always #5 refclk = ~refclk;

  typedef struct { int ch; int c; } ev_t;
  ev_t sb_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0, L = 0;
  int sh_div [NCH], sh_ph [NCH], ac_div [NCH], ac_ph [NCH];
  logic [3:0] sh_en, ac_en, old_en;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  function automatic bit run_at(int c);
    return c >= L + 1 + LC;
  endfunction

  // closed-form counter value relative to the LOAD cycle L
  function automatic int cnt_at(int ch, int c);
    return (ac_ph[ch] + c - L - 1) % ac_div[ch];
  endfunction

  function automatic logic [3:0] exp_out(int c);
    logic [3:0] r;
    r = '0;
    for (int ch = 0; ch < NCH; ch++)
      r[ch] = run_at(c) && ac_en[ch] && (cnt_at(ch, c) < (ac_div[ch] + 1) / 2);
    return r;
  endfunction

  function automatic logic [3:0] exp_act(int c);
    return (c > L) ? ac_en : old_en;
  endfunction

  function automatic int find_ev(int ch, int c);
    int idx;
    idx = -1;
    foreach (sb_q[j]) if (sb_q[j].c == c && sb_q[j].ch == ch) idx = j;
    return idx;
  endfunction

  task automatic sb_push(int lo, int hi);
    for (int c = lo; c <= hi; c++)
      for (int ch = 0; ch < NCH; ch++)
        if (run_at(c) && ac_en[ch] && cnt_at(ch, c) == ac_div[ch] - 1)
          sb_q.push_back('{ch: ch, c: c});
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      sh_div[ch] = INIT_DIV[ch];
      sh_ph[ch]  = 0;
      ac_div[ch] = INIT_DIV[ch];
      ac_ph[ch]  = 0;
    end
    sh_en  = 4'b1111;
    ac_en  = 4'b1111;
    old_en = 4'b0000;
    L      = 0;
  endtask

  task automatic book_commit(int win);
    L      = cyc + 2;
    old_en = ac_en;
    for (int ch = 0; ch < NCH; ch++) begin
      ac_div[ch] = sh_div[ch];
      ac_ph[ch]  = sh_ph[ch];
    end
    ac_en = sh_en;
    sb_q.delete();
    sb_push(cyc + 1, cyc + 1 + win);
  endtask

  task automatic do_write(int ch, int dv, int ph, bit en, bit cm, int win);
    int d;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    cfg_phase = 8'(ph);
    cfg_en    = en;
    cfg_valid = 1'b1;
    commit    = cm;
    d          = (dv == 0) ? 1 : dv;
    sh_div[ch] = d;
    sh_ph[ch]  = (ph >= d) ? d - 1 : ph;
    sh_en[ch]  = en;
    if (cm) book_commit(win);
    tick();
    cfg_valid = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_st;
    int pulses [NCH];
    int req [NCH];
    req = '{2, 4, 4, 7};
    pulses = '{0, 0, 0, 0};
    reset = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({clk_en, clk_out, ch_active} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 000", {clk_en, clk_out, ch_active});
    end
    n_chk++;
    if ({locked, busy, cfg_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_status got %b required 010", {locked, busy, cfg_ready});
    end
    model_reset();
    sb_q.delete();
    reset = 1'b0;
    cyc   = 0;
    sb_push(1, 100);
    repeat (100) begin
      tick();
      exp_st = run_at(cyc) ? 3'b101 : 3'b010;
      n_chk++;
      if ({locked, busy, cfg_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL reset_lock cyc=%0d got %b required %b", cyc, {locked, busy, cfg_ready}, exp_st);
      end
      n_chk++;
      if (clk_out !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL reset_clk_out cyc=%0d got %b required %b", cyc, clk_out, exp_out(cyc));
      end
      n_chk++;
      if (ch_active !== exp_act(cyc)) begin
        n_fail++;
        $display("FAIL reset_active cyc=%0d got %b required %b", cyc, ch_active, exp_act(cyc));
      end
      for (int ch = 0; ch < NCH; ch++) if (clk_en[ch]) begin
        int idx;
        idx = find_ev(ch, cyc);
        n_chk++;
        pulses[ch]++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL reset_clk_en ch%0d cyc=%0d got 1 required 0", ch, cyc);
        end else sb_q.delete(idx);
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].c <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL reset_clk_en ch%0d cyc=%0d got 0 required 1", sb_q[j].ch, sb_q[j].c);
        sb_q.delete(j);
      end
    end
    for (int ch = 0; ch < NCH; ch++) begin
      n_chk++;
      if (pulses[ch] != req[ch]) begin
        n_fail++;
        $display("FAIL reset_pulse_count ch%0d got %0d required %0d", ch, pulses[ch], req[ch]);
      end
    end
  endtask

  task automatic test_phase();
    logic [2:0] exp_st;
    int f2, s2, f3;
    f2 = -1; s2 = -1; f3 = -1;
    do_write(2, 4, 2, 1'b1, 1'b0, 0);
    do_write(3, 4, 0, 1'b1, 1'b1, 60);
    repeat (60) begin
      tick();
      exp_st = run_at(cyc) ? 3'b101 : 3'b010;
      n_chk++;
      if ({locked, busy, cfg_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL phase_status cyc=%0d got %b required %b", cyc, {locked, busy, cfg_ready}, exp_st);
      end
      n_chk++;
      if (clk_out !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL phase_clk_out cyc=%0d got %b required %b", cyc, clk_out, exp_out(cyc));
      end
      n_chk++;
      if (ch_active !== exp_act(cyc)) begin
        n_fail++;
        $display("FAIL phase_active cyc=%0d got %b required %b", cyc, ch_active, exp_act(cyc));
      end
      if (clk_en[2]) begin if (f2 < 0) f2 = cyc; else if (s2 < 0) s2 = cyc; end
      if (clk_en[3] && f3 < 0) f3 = cyc;
      for (int ch = 0; ch < NCH; ch++) if (clk_en[ch]) begin
        int idx;
        idx = find_ev(ch, cyc);
        n_chk++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL phase_clk_en ch%0d cyc=%0d got 1 required 0", ch, cyc);
        end else sb_q.delete(idx);
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].c <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL phase_clk_en ch%0d cyc=%0d got 0 required 1", sb_q[j].ch, sb_q[j].c);
        sb_q.delete(j);
      end
    end
    n_chk++;
    if (f2 < 0 || f3 - f2 != 2) begin
      n_fail++;
      $display("FAIL phase_lead ch3-ch2 got %0d required 2", f3 - f2);
    end
    n_chk++;
    if (s2 - f2 != 4) begin
      n_fail++;
      $display("FAIL phase_period ch2 got %0d required 4", s2 - f2);
    end
  endtask

  task automatic test_sanitise();
    logic [2:0] exp_st;
    int n1, nrun, n0;
    n1 = 0; nrun = 0; n0 = 0;
    do_write(1, 0, 5, 1'b1, 1'b0, 0);
    do_write(0, 48, 200, 1'b1, 1'b1, 70);
    repeat (70) begin
      tick();
      if (run_at(cyc)) nrun++;
      if (clk_en[1]) n1++;
      if (clk_en[0]) n0++;
      exp_st = run_at(cyc) ? 3'b101 : 3'b010;
      n_chk++;
      if ({locked, busy, cfg_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL sanitise_status cyc=%0d got %b required %b", cyc, {locked, busy, cfg_ready}, exp_st);
      end
      n_chk++;
      if (clk_out !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL sanitise_clk_out cyc=%0d got %b required %b", cyc, clk_out, exp_out(cyc));
      end
      for (int ch = 0; ch < NCH; ch++) if (clk_en[ch]) begin
        int idx;
        idx = find_ev(ch, cyc);
        n_chk++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL sanitise_clk_en ch%0d cyc=%0d got 1 required 0", ch, cyc);
        end else sb_q.delete(idx);
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].c <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL sanitise_clk_en ch%0d cyc=%0d got 0 required 1", sb_q[j].ch, sb_q[j].c);
        sb_q.delete(j);
      end
    end
    n_chk++;
    if (n1 != nrun) begin
      n_fail++;
      $display("FAIL sanitise_div0 ch1 pulses got %0d required %0d", n1, nrun);
    end
    n_chk++;
    if (n0 != 1) begin
      n_fail++;
      $display("FAIL sanitise_phase ch0 pulses got %0d required 1", n0);
    end
  endtask

  task automatic test_busy_commit();
    logic [2:0] exp_st;
    do_write(0, 48, 47, 1'b1, 1'b1, LC + 32);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd9; cfg_phase = 8'd1; cfg_en = 1'b1;
    repeat (LC + 32) begin
      tick();
      exp_st = run_at(cyc) ? 3'b101 : 3'b010;
      n_chk++;
      if ({locked, busy, cfg_ready} !== exp_st) begin
        n_fail++;
        $display("FAIL busy_status cyc=%0d got %b required %b", cyc, {locked, busy, cfg_ready}, exp_st);
      end
      n_chk++;
      if (clk_out !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL busy_clk_out cyc=%0d got %b required %b", cyc, clk_out, exp_out(cyc));
      end
      for (int ch = 0; ch < NCH; ch++) if (clk_en[ch]) begin
        int idx;
        idx = find_ev(ch, cyc);
        n_chk++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL busy_clk_en ch%0d cyc=%0d got 1 required 0", ch, cyc);
        end else sb_q.delete(idx);
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].c <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL busy_clk_en ch%0d cyc=%0d got 0 required 1", sb_q[j].ch, sb_q[j].c);
        sb_q.delete(j);
      end
      cfg_valid = (cyc < L + LC);
      commit    = (cyc == L + 3);
    end
    cfg_valid = 1'b0;
    commit    = 1'b0;
  endtask

  task automatic test_disable();
    int n0;
    n0 = 0;
    do_write(0, 48, 0, 1'b0, 1'b1, 60);
    repeat (60) begin
      tick();
      if (clk_en[0] || clk_out[0]) n0++;
      n_chk++;
      if (locked !== run_at(cyc)) begin
        n_fail++;
        $display("FAIL disable_locked cyc=%0d got %b required %b", cyc, locked, run_at(cyc));
      end
      n_chk++;
      if (clk_out !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL disable_clk_out cyc=%0d got %b required %b", cyc, clk_out, exp_out(cyc));
      end
      n_chk++;
      if (ch_active !== exp_act(cyc)) begin
        n_fail++;
        $display("FAIL disable_active cyc=%0d got %b required %b", cyc, ch_active, exp_act(cyc));
      end
      for (int ch = 0; ch < NCH; ch++) if (clk_en[ch]) begin
        int idx;
        idx = find_ev(ch, cyc);
        n_chk++;
        if (idx < 0) begin
          n_fail++;
          $display("FAIL disable_clk_en ch%0d cyc=%0d got 1 required 0", ch, cyc);
        end else sb_q.delete(idx);
      end
      for (int j = sb_q.size() - 1; j >= 0; j--) if (sb_q[j].c <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL disable_clk_en ch%0d cyc=%0d got 0 required 1", sb_q[j].ch, sb_q[j].c);
        sb_q.delete(j);
      end
    end
    n_chk++;
    if (ch_active !== 4'b1110) begin
      n_fail++;
      $display("FAIL disable_ch_active got %b required 1110", ch_active);
    end
    n_chk++;
    if (n0 != 0) begin
      n_fail++;
      $display("FAIL disable_ch0_quiet got %0d active cycles required 0", n0);
    end
  endtask

  task automatic test_reset_midlock();
    do_write(3, 5, 0, 1'b1, 1'b1, 0);
    while (cyc < L + 3) tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if ({clk_en, clk_out, ch_active} !== 12'h000) begin
      n_fail++;
      $display("FAIL midlock_outputs got %h required 000", {clk_en, clk_out, ch_active});
    end
    n_chk++;
    if ({locked, busy, cfg_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL midlock_status got %b required 010", {locked, busy, cfg_ready});
    end
    test_reset();
  endtask

  initial begin
    test_reset();
    test_phase();
    test_sanitise();
    test_busy_commit();
    test_disable();
    test_reset_midlock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
